// File: rtl/muldiv_ctrl_pkg.sv
// Shared types, op codes and helpers for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

   localparam int DATA_W  = 32;
   localparam int DWORD_W = 64;
   localparam int ALUOP_W = 8;
   localparam int CNT_W   = 5;

   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [DWORD_W-1:0] dword_t;
   typedef logic [ALUOP_W-1:0] aluop_t;

   localparam aluop_t ALU_NOP   = 8'h00;
   localparam aluop_t ALU_ADD   = 8'h01;
   localparam aluop_t ALU_SUB   = 8'h02;
   localparam aluop_t ALU_MUL   = 8'h10;
   localparam aluop_t ALU_MULT  = 8'h11;
   localparam aluop_t ALU_MULTU = 8'h12;
   localparam aluop_t ALU_MADD  = 8'h13;
   localparam aluop_t ALU_MADDU = 8'h14;
   localparam aluop_t ALU_MSUB  = 8'h15;
   localparam aluop_t ALU_MSUBU = 8'h16;
   localparam aluop_t ALU_DIV   = 8'h17;
   localparam aluop_t ALU_DIVU  = 8'h18;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_RUN  = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   function automatic logic is_mul_signed(input aluop_t op);
      return op inside {ALU_MUL, ALU_MULT, ALU_MADD, ALU_MSUB};
   endfunction

   function automatic logic is_mul_unsigned(input aluop_t op);
      return op inside {ALU_MULTU, ALU_MADDU, ALU_MSUBU};
   endfunction

   function automatic logic is_div(input aluop_t op);
      return op inside {ALU_DIV, ALU_DIVU};
   endfunction

   // 0x80000000 comes back unchanged, which read as unsigned is 2^31.
   function automatic data_t abs_mag(input data_t x);
      return x[DATA_W-1] ? data_t'(-x) : x;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Radix-2 restoring divider core: remainder/quotient/divisor registers and iteration counter.
module div_radix2
   import muldiv_ctrl_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  start,
   input  logic  abort,
   input  logic  en,
   input  data_t dividend,
   input  data_t divisor,
   output logic  last,
   output data_t quo,
   output data_t rem
);

   data_t            rem_q, rem_d;
   data_t            quo_q, quo_d;
   data_t            dsr_q, dsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W:0]  shifted;
   data_t            diff;
   logic             fits;

   // A successful trial leaves a result below 2^32, so the low 32 bits are exact.
   assign shifted = {rem_q, quo_q[DATA_W-1]};
   assign fits    = shifted >= {1'b0, dsr_q};
   assign diff    = shifted[DATA_W-1:0] - dsr_q;

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dsr_d = dsr_q;
      cnt_d = cnt_q;
      if (abort) begin
         cnt_d = '0;
      end else if (start) begin
         rem_d = '0;
         quo_d = dividend;
         dsr_d = divisor;
         cnt_d = '0;
      end else if (en) begin
         rem_d = shifted[DATA_W-1:0];
         quo_d = {quo_q[DATA_W-2:0], 1'b0};
         if (fits) begin
            rem_d    = diff;
            quo_d[0] = 1'b1;
         end
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dsr_q <= dsr_d;
         cnt_q <= cnt_d;
      end
   end

   // quo/rem present the outcome of the iteration in progress, ready to capture on the last one.
   assign last = (cnt_q == CNT_W'(DIV_ITER - 1));
   assign quo  = quo_d;
   assign rem  = rem_d;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: registered 16x16 partial products, 32-step divider, stall request.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic   clk,
   input  logic   rst,
   input  aluop_t aluop,
   input  data_t  opr1,
   input  data_t  opr2,
   input  logic   stall_i,
   input  logic   flush,
   output dword_t mulhi,
   output dword_t mullo,
   output logic   mul_s,
   output dword_t divres,
   output logic   stallreq
);

   // state    | meaning
   // MDU_IDLE | no division active; a divide op in EX starts one
   // MDU_RUN  | one restoring iteration per cycle, pipeline held
   // MDU_DONE | divres valid; wait for the divide op to leave EX

   mdu_state_e state_q, state_d;
   dword_t     mulhi_q, mulhi_d;
   dword_t     mullo_q, mullo_d;
   logic       mul_s_q, mul_s_d;
   dword_t     divres_q, divres_d;
   logic       qsign_q, qsign_d;
   logic       rsign_q, rsign_d;

   logic       kill, mul_sgn, mul_op, div_op, div_sgn;
   logic       div_start, mul_ld, dv_last, dv_en, stall_req;
   data_t      mag1, mag2, dv_quo, dv_rem;
   data_t      pp_hh, pp_lh, pp_hl, pp_ll;

   // Reset mid-division behaves like a flush on top of clearing the registers.
   assign kill    = flush | rst;
   assign mul_sgn = is_mul_signed(aluop);
   assign mul_op  = mul_sgn | is_mul_unsigned(aluop);
   assign div_op  = is_div(aluop);
   assign div_sgn = (aluop == ALU_DIV);
   assign mag1    = (mul_sgn | div_sgn) ? abs_mag(opr1) : opr1;
   assign mag2    = (mul_sgn | div_sgn) ? abs_mag(opr2) : opr2;

   assign pp_hh = {16'b0, mag1[31:16]} * {16'b0, mag2[31:16]};
   assign pp_lh = {16'b0, mag1[15:0]}  * {16'b0, mag2[31:16]};
   assign pp_hl = {16'b0, mag1[31:16]} * {16'b0, mag2[15:0]};
   assign pp_ll = {16'b0, mag1[15:0]}  * {16'b0, mag2[15:0]};

   assign div_start = (state_q == MDU_IDLE) && div_op && !kill;
   assign dv_en     = (state_q == MDU_RUN) && !kill;
   assign stall_req = div_start || dv_en;
   assign mul_ld    = mul_op && !stall_i && !stall_req && !kill;

   div_radix2 #(.DIV_ITER(DIV_ITER)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .abort    (flush),
      .en       (dv_en),
      .dividend (mag1),
      .divisor  (mag2),
      .last     (dv_last),
      .quo      (dv_quo),
      .rem      (dv_rem)
   );

   always_comb begin
      state_d  = state_q;
      mulhi_d  = mulhi_q;
      mullo_d  = mullo_q;
      mul_s_d  = mul_s_q;
      divres_d = divres_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;

      unique case (state_q)
         MDU_IDLE: if (div_start) state_d = MDU_RUN;
         MDU_RUN:  if (dv_last)   state_d = MDU_DONE;
         MDU_DONE: if (!stall_i)  state_d = MDU_IDLE;
         default:                 state_d = MDU_IDLE;
      endcase
      if (kill) state_d = MDU_IDLE;

      if (div_start) begin
         qsign_d = div_sgn & (opr1[31] ^ opr2[31]);
         rsign_d = div_sgn & opr1[31];
      end

      if (dv_en && dv_last) begin
         divres_d = {rsign_q ? data_t'(-dv_rem) : dv_rem,
                     qsign_q ? data_t'(-dv_quo) : dv_quo};
      end

      if (mul_ld) begin
         mulhi_d = {pp_hh, pp_lh};
         mullo_d = {pp_hl, pp_ll};
         mul_s_d = mul_sgn & (opr1[31] ^ opr2[31]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MDU_IDLE;
         mulhi_q  <= '0;
         mullo_q  <= '0;
         mul_s_q  <= 1'b0;
         divres_q <= '0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mulhi_q  <= mulhi_d;
         mullo_q  <= mullo_d;
         mul_s_q  <= mul_s_d;
         divres_q <= divres_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
      end
   end

   assign mulhi    = mulhi_q;
   assign mullo    = mullo_q;
   assign mul_s    = mul_s_q;
   assign divres   = divres_q;
   assign stallreq = stall_req;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   aluop_t aluop;
   data_t  opr1, opr2;
   logic   stall_i, flush;
   dword_t mulhi, mullo, divres;
   logic   mul_s, stallreq;

   muldiv_ctrl #(.DIV_ITER(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .aluop    (aluop),
      .opr1     (opr1),
      .opr2     (opr2),
      .stall_i  (stall_i),
      .flush    (flush),
      .mulhi    (mulhi),
      .mullo    (mullo),
      .mul_s    (mul_s),
      .divres   (divres),
      .stallreq (stallreq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {K_MUL, K_DIV, K_STALL, K_ZERO} kind_e;
   typedef struct {
      int     due;
      kind_e  kind;
      dword_t hi;
      dword_t lo;
      logic   s;
      dword_t prod;
      dword_t dres;
      logic   sreq;
      string  name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference state: what the architectural outputs should hold right now
   dword_t m_hi = '0, m_lo = '0, m_prod = '0, m_div = '0;
   logic   m_s = 1'b0;

   function automatic bit op_signed_mul(input aluop_t op);
      return op == ALU_MUL || op == ALU_MULT || op == ALU_MADD || op == ALU_MSUB;
   endfunction

   function automatic longint unsigned magnitude(input data_t x, input bit sg);
      longint unsigned m;
      m = {32'b0, x};
      if (sg && x[31]) m = 64'h1_0000_0000 - m;
      return m;
   endfunction

   function automatic void ref_pp(input aluop_t op, input data_t a, input data_t b,
                                  output dword_t hi, output dword_t lo, output logic s);
      bit sg;
      longint unsigned ma, mb, ah, al, bh, bl;
      sg = op_signed_mul(op);
      ma = magnitude(a, sg);
      mb = magnitude(b, sg);
      ah = ma / 65536; al = ma % 65536;
      bh = mb / 65536; bl = mb % 65536;
      hi = (ah * bh) * 64'h1_0000_0000 + al * bh;
      lo = (ah * bl) * 64'h1_0000_0000 + al * bl;
      s  = sg && (a[31] != b[31]);
   endfunction

   function automatic dword_t ref_product(input aluop_t op, input data_t a, input data_t b);
      longint sa, sb2;
      if (op_signed_mul(op)) begin
         sa  = longint'($signed(a));
         sb2 = longint'($signed(b));
         return dword_t'(sa * sb2);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic dword_t ref_div(input aluop_t op, input data_t a, input data_t b);
      bit sg;
      longint unsigned ma, mb, q, r;
      data_t q32, r32;
      sg = (op == ALU_DIV);
      ma = magnitude(a, sg);
      mb = magnitude(b, sg);
      if (mb == 0) begin
         q = 64'hFFFF_FFFF;
         r = ma;
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      q32 = q[31:0];
      r32 = r[31:0];
      if (sg && (a[31] != b[31])) q32 = -q32;
      if (sg && a[31])            r32 = -r32;
      return {r32, q32};
   endfunction

   // how MEM would fold the four partial products into the final product
   function automatic dword_t combine(input dword_t hi, input dword_t lo, input logic s);
      dword_t p;
      p = {hi[63:32], 32'h0} + ({32'h0, hi[31:0]} << 16) + ({32'h0, lo[63:32]} << 16)
          + {32'h0, lo[31:0]};
      return s ? -p : p;
   endfunction

   function automatic exp_t mk(input int due, input kind_e k, input string nm);
      exp_t e;
      e.due = due; e.kind = k; e.name = nm;
      e.hi = '0; e.lo = '0; e.s = 1'b0; e.prod = '0; e.dres = '0; e.sreq = 1'b0;
      return e;
   endfunction

   function automatic void push_stall(input int due, input logic v, input string nm);
      exp_t e;
      e = mk(due, K_STALL, nm);
      e.sreq = v;
      sb.push_back(e);
   endfunction

   function automatic void push_mul(input int due, input dword_t hi, input dword_t lo,
                                    input logic s, input dword_t prod, input string nm);
      exp_t e;
      e = mk(due, K_MUL, nm);
      e.hi = hi; e.lo = lo; e.s = s; e.prod = prod;
      sb.push_back(e);
   endfunction

   function automatic void push_div(input int due, input dword_t d, input string nm);
      exp_t e;
      e = mk(due, K_DIV, nm);
      e.dres = d;
      sb.push_back(e);
   endfunction

   function automatic void check(input string nm, input dword_t act, input dword_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endfunction

   function automatic void evaluate(input exp_t e);
      case (e.kind)
         K_MUL: begin
            check({e.name, ".mulhi"}, mulhi, e.hi);
            check({e.name, ".mullo"}, mullo, e.lo);
            check({e.name, ".mul_s"}, {63'b0, mul_s}, {63'b0, e.s});
            check({e.name, ".product"}, combine(mulhi, mullo, mul_s), e.prod);
         end
         K_DIV:   check({e.name, ".divres"}, divres, e.dres);
         K_STALL: check({e.name, ".stallreq"}, {63'b0, stallreq}, {63'b0, e.sreq});
         default: begin
            check({e.name, ".mulhi"}, mulhi, '0);
            check({e.name, ".mullo"}, mullo, '0);
            check({e.name, ".mul_s"}, {63'b0, mul_s}, '0);
            check({e.name, ".divres"}, divres, '0);
         end
      endcase
   endfunction

   int mi;
   always @(negedge clk) begin
      mi = 0;
      while (mi < sb.size()) begin
         if (sb[mi].due == cyc) begin
            evaluate(sb[mi]);
            sb.delete(mi);
         end else if (sb[mi].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cyc %0d never evaluated", sb[mi].name, sb[mi].due);
            sb.delete(mi);
         end else begin
            mi++;
         end
      end
   end

   task automatic drive(input aluop_t op, input data_t a, input data_t b,
                        input logic stl, input logic fl);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      aluop   = op;
      opr1    = a;
      opr2    = b;
      stall_i = stl;
      flush   = fl;
   endtask

   task automatic do_mul(input aluop_t op, input data_t a, input data_t b, input logic stl,
                         input logic fl, input bit use_k, input dword_t k_hi,
                         input dword_t k_lo, input logic k_s, input dword_t k_prod);
      drive(op, a, b, stl, fl);
      if (!stl && !fl) begin
         ref_pp(op, a, b, m_hi, m_lo, m_s);
         m_prod = ref_product(op, a, b);
      end
      if (use_k) push_mul(cyc + 1, k_hi, k_lo, k_s, k_prod, "mul_const");
      else       push_mul(cyc + 1, m_hi, m_lo, m_s, m_prod, "mul");
      push_stall(cyc, 1'b0, "mul_sreq");
   endtask

   // abort_at in 1..32 flushes (or resets) during that RUN cycle; -1 lets it complete
   task automatic do_div(input aluop_t op, input data_t a, input data_t b, input int abort_at,
                         input bit abort_rst, input int done_stall, input bit use_k,
                         input dword_t k_res);
      dword_t nd;
      nd = use_k ? k_res : ref_div(op, a, b);
      drive(op, a, b, 1'b0, 1'b0);
      push_stall(cyc, 1'b1, "div_start");
      for (int k = 1; k <= 32; k++) begin
         if (k == abort_at) begin
            drive(op, a, b, 1'b0, !abort_rst);
            if (abort_rst) rst = 1'b1;
            push_stall(cyc, 1'b0, "div_abort");
            if (abort_rst) begin
               m_hi = '0; m_lo = '0; m_s = 1'b0; m_prod = '0; m_div = '0;
               sb.push_back(mk(cyc + 1, K_ZERO, "rst_mid_div"));
            end else begin
               push_div(cyc + 1, m_div, "flush_hold");
            end
            return;
         end
         drive(op, a, b, 1'b0, 1'b0);
         push_stall(cyc, 1'b1, "div_run");
      end
      m_div = nd;
      for (int j = 0; j <= done_stall; j++) begin
         drive(op, a, b, j < done_stall, 1'b0);
         push_stall(cyc, 1'b0, "div_done");
         push_div(cyc, m_div, use_k ? "div_const" : "div");
      end
   endtask

   function automatic data_t rnd_opr();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return data_t'($urandom_range(0, 15));
         default: return data_t'($urandom);
      endcase
   endfunction

   function automatic aluop_t rnd_mul_op();
      case ($urandom_range(0, 6))
         0:       return ALU_MUL;
         1:       return ALU_MULT;
         2:       return ALU_MULTU;
         3:       return ALU_MADD;
         4:       return ALU_MADDU;
         5:       return ALU_MSUB;
         default: return ALU_MSUBU;
      endcase
   endfunction

   initial begin
      rst = 1'b1; aluop = ALU_NOP; opr1 = '0; opr2 = '0; stall_i = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(mk(cyc, K_ZERO, "reset"));
      push_stall(cyc, 1'b0, "reset_sreq");

      do_mul(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1,
             64'hFFFE0001_FFFE0001, 64'hFFFE0001_FFFE0001, 1'b0, 64'hFFFFFFFE_00000001);
      do_mul(ALU_MULT, 32'h8000_0000, 32'h0000_0002, 0, 0, 1,
             64'h0, 64'h00010000_00000000, 1'b1, 64'hFFFFFFFF_00000000);
      do_mul(ALU_MADD, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 0, '0, '0, 1'b0, '0);
      do_mul(ALU_MSUBU, 32'h0000_0003, 32'h0000_0005, 0, 1, 0, '0, '0, 1'b0, '0);
      do_mul(ALU_MSUB, 32'hFFFF_FFFD, 32'h0001_0007, 0, 0, 0, '0, '0, 1'b0, '0);

      do_div(ALU_DIV, 32'hFFFF_FFF9, 32'h2, -1, 0, 0, 1, 64'hFFFFFFFF_FFFFFFFD);
      do_div(ALU_DIVU, 32'h5, 32'h0, -1, 0, 0, 1, 64'h00000005_FFFFFFFF);
      do_div(ALU_DIVU, 32'd100, 32'd7, 10, 0, 0, 0, '0);
      do_div(ALU_DIVU, 32'd100, 32'd7, -1, 0, 0, 1, 64'h00000002_0000000E);
      do_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 3, 0, '0);
      do_mul(ALU_MULT, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, '0, '0, 1'b0, '0);
      do_div(ALU_DIV, 32'hFFFF_FF9C, 32'd3, -1, 0, 0, 0, '0);
      do_div(ALU_DIV, 32'd1000, 32'hFFFF_FFF9, -1, 0, 0, 0, '0);
      do_div(ALU_DIVU, 32'hDEAD_BEEF, 32'd13, 10, 1, 0, 0, '0);
      do_mul(ALU_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, '0, '0, 1'b0, '0);

      for (int it = 0; it < 60; it++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 5) begin
            do_mul(rnd_mul_op(), rnd_opr(), rnd_opr(), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, 0, '0, '0, 1'b0, '0);
         end else if (sel == 6) begin
            drive(ALU_ADD, rnd_opr(), rnd_opr(), 1'b0, 1'b0);
            push_stall(cyc, 1'b0, "nop_sreq");
            push_mul(cyc + 1, m_hi, m_lo, m_s, m_prod, "nop_hold");
         end else begin
            aluop_t op;
            data_t  dv;
            op = ($urandom_range(0, 1) == 1) ? ALU_DIV : ALU_DIVU;
            dv = ($urandom_range(0, 3) == 0) ? data_t'($urandom_range(0, 9)) : rnd_opr();
            do_div(op, rnd_opr(), dv,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 32)) : -1,
                   0, $urandom_range(0, 2), 0, '0);
         end
      end

      repeat (3) begin
         drive(ALU_NOP, '0, '0, 1'b0, 1'b0);
         push_stall(cyc, 1'b0, "tail_sreq");
      end
      for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
